// File: rtl/ft245_tx_arbiter_if.sv
// rtl/ft245_tx_arbiter_if.sv - requester and FT245 TX handshake bundle for the arbiter
interface ft245_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   REQ;
    logic [8*N_REQ-1:0] DATA;
    logic [N_REQ-1:0]   LAST;
    logic [N_REQ-1:0]   ACK;
    logic [N_REQ-1:0]   GRANT;
    logic               BUSY;
    logic               ERR;
    logic               TXEN;
    logic [7:0]         TX_DATA;
    logic               TX_VALID;
    logic               TX_DONE;

    // master is the arbiter; slave is the requesters plus FT245 driver side
    modport master (
        input  REQ, DATA, LAST, TX_VALID, TX_DONE,
        output ACK, GRANT, BUSY, ERR, TXEN, TX_DATA
    );

    modport slave (
        output REQ, DATA, LAST, TX_VALID, TX_DONE,
        input  ACK, GRANT, BUSY, ERR, TXEN, TX_DATA
    );
endinterface

// File: rtl/ft245_tx_arbiter.sv
// rtl/ft245_tx_arbiter.sv - round-robin packet arbiter in front of the FT245 TX driver
module ft245_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               CLK,
    input  logic               RST,
    ft245_tx_arbiter_if.master bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arbState;

    arbState          state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] pickIdx;
    logic [PTR_W-1:0] nextPtr;
    logic             pickValid;
    logic             lastQ;
    logic [CNT_W-1:0] wdCnt;
    logic             ownerReq;
    logic             ownerLast;
    logic [7:0]       ownerData;

    // Rotating priority search: lowest offset from ptr wins, so scan offsets downward.
    always_comb begin
        pickIdx   = ptr;
        pickValid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N_REQ;
            if (bus.REQ[idx]) begin
                pickIdx   = PTR_W'(idx);
                pickValid = 1'b1;
            end
        end
    end

    always_comb begin
        ownerReq  = bus.REQ[owner];
        ownerLast = bus.LAST[owner];
        ownerData = bus.DATA[{owner, 3'b000} +: 8];
        nextPtr   = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            lastQ       <= 1'b0;
            wdCnt       <= '0;
            bus.GRANT   <= '0;
            bus.ACK     <= '0;
            bus.BUSY    <= 1'b0;
            bus.ERR     <= 1'b0;
            bus.TXEN    <= 1'b0;
            bus.TX_DATA <= 8'h00;
        end else begin
            bus.TXEN <= 1'b0;
            bus.ACK  <= '0;
            bus.ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        owner     <= pickIdx;
                        bus.GRANT <= N_REQ'(1) << pickIdx;
                        bus.BUSY  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Grant stays put even if the owner drops REQ mid-packet.
                    if (ownerReq && !bus.TX_VALID) begin
                        bus.TX_DATA <= ownerData;
                        lastQ       <= ownerLast;
                        bus.TXEN    <= 1'b1;
                        bus.ACK     <= N_REQ'(1) << owner;
                        wdCnt       <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.TX_DONE) begin
                        if (lastQ) begin
                            bus.GRANT <= '0;
                            bus.BUSY  <= 1'b0;
                            ptr       <= nextPtr;
                            state     <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end else if (wdCnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        bus.ERR   <= 1'b1;
                        bus.GRANT <= '0;
                        bus.BUSY  <= 1'b0;
                        ptr       <= nextPtr;
                        state     <= IDLE;
                    end else begin
                        wdCnt <= wdCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// tb/tb_ft245_tx_arbiter.sv - scoreboard bench for ft245_tx_arbiter
module tb_ft245_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    ft245_tx_arbiter_if #(.N_REQ(N)) bus ();

    ft245_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [8:0] reqQ [N][$];
    logic [9:0] sbQ [$];
    int grantLog [$];
    int grantCycLog [$];
    int txenLog [$];
    int doneLog [$];
    int errLog [$];
    int relLog [$];
    int ackCount [N];
    int cyc        = 0;
    int reqRiseCyc = -1;
    int doneCnt    = 0;
    bit dropDone   = 1'b0;

    initial begin : model
        logic [N-1:0]   r;
        logic [8*N-1:0] d;
        logic [N-1:0]   l;
        logic [N-1:0]   prevGrant;
        logic           prevTxen;
        logic           prevErr;
        logic [9:0]     e;
        int             gi;
        prevGrant = '0;
        prevTxen  = 1'b0;
        prevErr   = 1'b0;
        for (int i = 0; i < N; i++) ackCount[i] = 0;
        bus.REQ = '0;
        bus.DATA = '0;
        bus.LAST = '0;
        bus.TX_DONE = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (bus.TXEN === 1'b1) begin
                txenLog.push_back(cyc);
                checkVal("txenRun", {31'd0, prevTxen}, 0);
                checkVal("sbHasEntry", {31'd0, sbQ.size() != 0}, 1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    checkVal("txData", bus.TX_DATA, e[7:0]);
                    checkVal("txenGrant", bus.GRANT, 4'(1) << e[9:8]);
                    checkVal("ack", bus.ACK, 4'(1) << e[9:8]);
                    checkVal("busyAtTxen", bus.BUSY, 1);
                end
            end else if (bus.ACK !== '0 && !RST) begin
                checkVal("ackWithoutTxen", bus.ACK, 0);
            end
            if (bus.ERR === 1'b1) begin
                errLog.push_back(cyc);
                checkVal("errRun", {31'd0, prevErr}, 0);
                checkVal("errRelease", {bus.BUSY, bus.GRANT}, 0);
            end
            for (int i = 0; i < N; i++) if (bus.ACK[i] === 1'b1) ackCount[i]++;
            if (prevGrant == '0 && bus.GRANT !== '0 && !$isunknown(bus.GRANT)) begin
                gi = -1;
                for (int i = 0; i < N; i++) if (bus.GRANT[i]) gi = i;
                grantLog.push_back(gi);
                grantCycLog.push_back(cyc);
            end
            if (prevGrant != '0 && bus.GRANT === '0) relLog.push_back(cyc);
            prevGrant = $isunknown(bus.GRANT) ? '0 : bus.GRANT;
            prevTxen  = (bus.TXEN === 1'b1);
            prevErr   = (bus.ERR === 1'b1);

            bus.TX_DONE = 1'b0;
            if (RST) begin
                doneCnt = 0;
            end else begin
                if (doneCnt > 0) begin
                    doneCnt--;
                    if (doneCnt == 0) begin
                        bus.TX_DONE = 1'b1;
                        doneLog.push_back(cyc);
                    end
                end
                if (bus.TXEN === 1'b1 && !dropDone) doneCnt = 3;
            end

            for (int i = 0; i < N; i++)
                if (bus.ACK[i] === 1'b1 && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
            r = '0;
            d = '0;
            l = '0;
            for (int i = 0; i < N; i++) begin
                if (reqQ[i].size() > 0) begin
                    r[i]         = 1'b1;
                    d[8*i +: 8]  = reqQ[i][0][7:0];
                    l[i]         = reqQ[i][0][8];
                end
            end
            if (r != '0 && bus.REQ == '0) reqRiseCyc = cyc;
            bus.REQ  = r;
            bus.DATA = d;
            bus.LAST = l;
        end
    end

    function automatic bit reqQEmpty();
        for (int i = 0; i < N; i++) if (reqQ[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clearLogs();
        grantLog.delete();
        grantCycLog.delete();
        txenLog.delete();
        doneLog.delete();
        errLog.delete();
        relLog.delete();
    endtask

    task automatic doReset();
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < N; i++) reqQ[i].delete();
        sbQ.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        clearLogs();
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !(sbQ.size() == 0 && bus.BUSY === 1'b0 && reqQEmpty())) begin
            @(negedge CLK);
            n++;
        end
        checkVal({tag, ".done"}, {31'd0, n < budget}, 1);
        repeat (2) @(negedge CLK);
    endtask

    initial begin : main
        int fallCyc;
        int base [N];
        int n;
        bus.TX_VALID = 1'b0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checkVal("rst.grant",  bus.GRANT, 0);
        checkVal("rst.ack",    bus.ACK, 0);
        checkVal("rst.busy",   bus.BUSY, 0);
        checkVal("rst.err",    bus.ERR, 0);
        checkVal("rst.txen",   bus.TXEN, 0);
        checkVal("rst.txData", bus.TX_DATA, 8'h00);
        RST = 1'b0;

        // single byte
        doReset();
        reqQ[0].push_back({1'b1, 8'hA5});
        sbQ.push_back({2'd0, 8'hA5});
        waitIdle("single", 60);
        checkVal("single.grantIdx", grantLog[0], 0);
        checkVal("single.grantLat", grantCycLog[0] - reqRiseCyc, 1);
        checkVal("single.txenLat", txenLog[0] - reqRiseCyc, 2);
        checkVal("single.release", relLog[0] - doneLog[0], 1);

        // round robin, two single-byte packets per requester
        doReset();
        for (int i = 0; i < N; i++) base[i] = ackCount[i];
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                reqQ[i].push_back({1'b1, 8'(16 * i + r)});
                sbQ.push_back({2'(i), 8'(16 * i + r)});
            end
        end
        waitIdle("rr", 200);
        checkVal("rr.grants", grantLog.size(), 8);
        for (int k = 0; k < 8; k++) checkVal("rr.order", grantLog[k], k % N);
        for (int i = 0; i < N; i++) checkVal("rr.ackCount", ackCount[i] - base[i], 2);

        // packet lock
        doReset();
        reqQ[1].push_back({1'b0, 8'h11});
        reqQ[1].push_back({1'b0, 8'h22});
        reqQ[1].push_back({1'b1, 8'h33});
        reqQ[2].push_back({1'b1, 8'h44});
        sbQ.push_back({2'd1, 8'h11});
        sbQ.push_back({2'd1, 8'h22});
        sbQ.push_back({2'd1, 8'h33});
        sbQ.push_back({2'd2, 8'h44});
        waitIdle("lock", 120);
        checkVal("lock.grants", grantLog.size(), 2);
        checkVal("lock.first", grantLog[0], 1);
        checkVal("lock.second", grantLog[1], 2);
        checkVal("lock.byteGap1", txenLog[1] - doneLog[0], 2);
        checkVal("lock.byteGap2", txenLog[2] - doneLog[1], 2);
        checkVal("lock.regrant", grantCycLog[1] - doneLog[2], 2);

        // back-pressure
        doReset();
        bus.TX_VALID = 1'b1;
        reqQ[3].push_back({1'b1, 8'h5A});
        sbQ.push_back({2'd3, 8'h5A});
        repeat (12) @(negedge CLK);
        checkVal("bp.noTxen", txenLog.size(), 0);
        checkVal("bp.grant", bus.GRANT, 4'b1000);
        bus.TX_VALID = 1'b0;
        fallCyc = cyc;
        waitIdle("bp", 40);
        checkVal("bp.txenLat", txenLog[0] - fallCyc, 1);

        // watchdog
        doReset();
        dropDone = 1'b1;
        reqQ[0].push_back({1'b0, 8'h77});
        reqQ[1].push_back({1'b1, 8'h99});
        sbQ.push_back({2'd0, 8'h77});
        sbQ.push_back({2'd1, 8'h99});
        n = 0;
        while (errLog.size() == 0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        dropDone = 1'b0;
        checkVal("wd.errSeen", errLog.size(), 1);
        waitIdle("wd", 60);
        checkVal("wd.errLat", errLog[0] - txenLog[0], TMO);
        checkVal("wd.errCount", errLog.size(), 1);
        checkVal("wd.releaseWithErr", relLog[0], errLog[0]);
        checkVal("wd.next", grantLog[1], 1);
        checkVal("wd.nextLat", grantCycLog[1] - errLog[0], 1);

        // reset mid-packet
        doReset();
        dropDone = 1'b1;
        reqQ[0].push_back({1'b1, 8'hC3});
        sbQ.push_back({2'd0, 8'hC3});
        n = 0;
        while (txenLog.size() == 0 && n < 30) begin
            @(negedge CLK);
            n++;
        end
        checkVal("mid.txenSeen", txenLog.size(), 1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checkVal("mid.grant", bus.GRANT, 0);
        checkVal("mid.busy", bus.BUSY, 0);
        checkVal("mid.pulses", {bus.ACK, bus.ERR, bus.TXEN}, 0);
        checkVal("mid.txData", bus.TX_DATA, 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        dropDone = 1'b0;
        clearLogs();
        reqQ[2].push_back({1'b1, 8'hE1});
        sbQ.push_back({2'd2, 8'hE1});
        waitIdle("mid", 60);
        checkVal("mid.regrant", grantLog[0], 2);
        checkVal("mid.txenCount", txenLog.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : guard
        #500000;
        $display("FAIL globalTimeout: got running expected finished");
        $fatal(1);
    end
endmodule
